// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - opcode constants and FSM state encoding for alu_arbiter
//
// Shared by alu_arbiter and its testbench; no ports.
package alu_ctrl_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC1 = 2'd1,
    EXEC2 = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with last-grant pointer
//
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   en        arbitration allowed this cycle (owner is idle)
//   req[1:0]  request per requester
//   gnt[1:0]  one-hot grant; a grant is a handshake since ready == grant
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Index of the requester granted most recently; reset to 1 so that
  // requester 0 wins the first tie.
  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = last_grant ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (|gnt) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester command arbiter driving a shared external ALU
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/ready/op/a/b       requester N command channel (N = 0, 1)
//   rsp_valid/ready/id/data       result channel back to the consumer
//   alu_a, alu_b, alu_and, alu_add  shared ALU operands and operation selects
//   alu_out                       shared ALU result (combinational)
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int bit_size = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [bit_size:0] req0_a,
  input  logic [bit_size:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [bit_size:0] req1_a,
  input  logic [bit_size:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [bit_size:0] rsp_data,
  output logic [bit_size:0] alu_a,
  output logic [bit_size:0] alu_b,
  output logic              alu_and,
  output logic              alu_add,
  input  logic [bit_size:0] alu_out
);

  state_t            state, state_nxt;
  logic [bit_size:0] a_reg, b_reg, result_reg;
  logic [1:0]        op_reg;
  logic              id_reg;
  logic [1:0]        gnt;
  logic              arb_en;
  logic              accept;

  // Gating with rst keeps a handshake from landing in a reset cycle.
  assign arb_en = (state == IDLE) && !rst;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req ({req1_valid, req0_valid}),
    .gnt (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign accept     = |gnt;

  always_comb begin
    state_nxt = state;
    alu_a     = '0;
    alu_b     = '0;
    alu_and   = 1'b0;
    alu_add   = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = 1'b0;
    rsp_data  = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (accept) state_nxt = EXEC1;
        end
        EXEC1: begin
          alu_a = a_reg;
          case (op_reg)
            OP_AND:  begin alu_b = b_reg;  alu_and = 1'b1; end
            OP_ADD:  begin alu_b = b_reg;  alu_add = 1'b1; end
            // Subtraction as a + ~b, with the +1 applied in EXEC2.
            OP_SUB:  begin alu_b = ~b_reg; alu_add = 1'b1; end
            default: begin alu_b = '1;     alu_and = 1'b1; end
          endcase
          state_nxt = (op_reg == OP_SUB) ? EXEC2 : RESP;
        end
        EXEC2: begin
          alu_a     = result_reg;
          alu_b     = {{bit_size{1'b0}}, 1'b1};
          alu_add   = 1'b1;
          state_nxt = RESP;
        end
        RESP: begin
          rsp_valid = 1'b1;
          rsp_id    = id_reg;
          rsp_data  = result_reg;
          if (rsp_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= 2'b00;
      id_reg     <= 1'b0;
      result_reg <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_reg  <= gnt[1] ? req1_a  : req0_a;
        b_reg  <= gnt[1] ? req1_b  : req0_b;
        op_reg <= gnt[1] ? req1_op : req0_op;
        id_reg <= gnt[1];
      end
      if (state == EXEC1 || state == EXEC2) begin
        result_reg <= alu_out;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with behavioural result/arbitration model
module tb_alu_arbiter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_data, alu_a, alu_b, alu_out;
  logic         alu_and, alu_add;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External ALU
  always_comb begin
    if (alu_and)      alu_out = alu_a & alu_b;
    else if (alu_add) alu_out = alu_a + alu_b;
    else              alu_out = '0;
  end

  alu_arbiter #(.bit_size(15)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_and(alu_and), .alu_add(alu_add), .alu_out(alu_out)
  );

  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a + b;
      2'd2:    return a - b;
      default: return a;
    endcase
  endfunction

  always @(negedge clk) begin
    checks++;
    if (alu_and && alu_add) begin
      errors++;
      $display("FAIL alu_sel_exclusive: alu_and=%0b alu_add=%0b, required not both 1", alu_and, alu_add);
    end
  end

  // Presents a command on requester id and waits (bounded) for its grant.
  // Returns at negedge of the cycle after the handshake plus #1, valids dropped.
  task automatic issue(input bit id, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 2'd1; req0_a = 16'h0011; req0_b = 16'h0022;
    req1_valid = 1'b1; req1_op = 2'd0; req1_a = 16'h0033; req1_b = 16'h0044;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, alu_a, alu_b, alu_and, alu_add} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: r0=%0b r1=%0b rv=%0b id=%0b d=%h a=%h b=%h and=%0b add=%0b, required all 0",
               req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, alu_a, alu_b, alu_and, alu_add);
    end
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || alu_and !== 1'b0 || alu_add !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_cmd: rsp_valid=%0b and=%0b add=%0b, required 0", rsp_valid, alu_and, alu_add);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_add();
    bit ok;
    rsp_ready = 1'b1;
    issue(1'b0, 2'd1, 16'h0003, 16'h0004, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL add_grant: no grant within 20 cycles, required grant"); end
    checks++;
    if (rsp_valid !== 1'b0 || alu_add !== 1'b1 || alu_b !== 16'h0004) begin
      errors++;
      $display("FAIL add_t1: rsp_valid=%0b add=%0b alu_b=%h, required 0/1/0004", rsp_valid, alu_add, alu_b);
    end
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h0007 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL add_t2: rsp_valid=%0b data=%h id=%0b, required 1/0007/0", rsp_valid, rsp_data, rsp_id);
    end
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_done: rsp_valid=%0b, required 0", rsp_valid); end
  endtask

  task automatic test_sub_wrap();
    bit ok;
    rsp_ready = 1'b1;
    issue(1'b1, 2'd2, 16'h0002, 16'h0005, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL sub_grant: no grant within 20 cycles, required grant"); end
    checks++;
    if (alu_b !== 16'hFFFA || alu_a !== 16'h0002 || alu_add !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL sub_exec1: alu_a=%h alu_b=%h add=%0b rv=%0b, required 0002/FFFA/1/0", alu_a, alu_b, alu_add, rsp_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (alu_b !== 16'h0001 || alu_add !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL sub_exec2: alu_b=%h add=%0b rv=%0b, required 0001/1/0", alu_b, alu_add, rsp_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'hFFFD || rsp_id !== 1'b1) begin
      errors++;
      $display("FAIL sub_t3: rsp_valid=%0b data=%h id=%0b, required 1/FFFD/1", rsp_valid, rsp_data, rsp_id);
    end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    int grants[$];
    int nrsp = 0;
    bit exp_ids[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    rsp_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 2'd0; req0_a = 16'hF0F0; req0_b = 16'h0FF0;
    req1_valid = 1'b1; req1_op = 2'd0; req1_a = 16'hF0F0; req1_b = 16'h0FF0;
    for (int cyc = 0; cyc < 60 && nrsp < 4; cyc++) begin
      #1;
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (rsp_valid) begin
        checks++;
        if (rsp_data !== 16'h00F0 || rsp_id !== exp_ids[nrsp]) begin
          errors++;
          $display("FAIL fair_rsp%0d: data=%h id=%0b, required 00F0/%0b", nrsp, rsp_data, rsp_id, exp_ids[nrsp]);
        end
        nrsp++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (nrsp != 4 || grants.size() < 4) begin
      errors++;
      $display("FAIL fair_count: responses=%0d grants=%0d, required 4/4", nrsp, grants.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grants[i] != int'(exp_ids[i])) begin
          errors++;
          $display("FAIL fair_grant%0d: got %0d, required %0d", i, grants[i], exp_ids[i]);
        end
      end
    end
  endtask

  task automatic test_pass();
    bit ok;
    logic [W-1:0] b = 16'($urandom);
    rsp_ready = 1'b1;
    issue(1'b0, 2'd3, 16'h1234, b, ok);
    checks++;
    if (!ok || alu_b !== 16'hFFFF || alu_and !== 1'b1 || alu_add !== 1'b0) begin
      errors++;
      $display("FAIL pass_exec1: ok=%0b alu_b=%h and=%0b add=%0b, required 1/FFFF/1/0", ok, alu_b, alu_and, alu_add);
    end
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL pass_rsp: rsp_valid=%0b data=%h id=%0b, required 1/1234/0", rsp_valid, rsp_data, rsp_id);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [W-1:0] a = 16'($urandom);
    logic [W-1:0] b = 16'($urandom);
    logic [W-1:0] exp = ref_result(2'd1, a, b);
    rsp_ready = 1'b0;
    issue(1'b1, 2'd1, a, b, ok);
    @(negedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (!ok || rsp_valid !== 1'b1 || rsp_data !== exp || rsp_id !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: rv=%0b data=%h id=%0b r0=%0b r1=%0b, required 1/%h/1/0/0",
                 i, rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready, exp);
      end
      @(negedge clk);
    end
    #1;
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: rv=%0b r0=%0b r1=%0b, required 0/1/0", rsp_valid, req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sub();
    bit ok;
    rsp_ready = 1'b1;
    issue(1'b0, 2'd2, 16'($urandom), 16'($urandom), ok);
    @(negedge clk); #1;
    checks++;
    if (!ok || alu_b !== 16'h0001 || alu_add !== 1'b1) begin
      errors++;
      $display("FAIL rst_sub_exec2: ok=%0b alu_b=%h add=%0b, required 1/0001/1", ok, alu_b, alu_add);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, alu_a, alu_b, alu_and, alu_add} !== '0) begin
      errors++;
      $display("FAIL rst_sub_idle: rv=%0b d=%h a=%h b=%h and=%0b add=%0b, required all 0",
               rsp_valid, rsp_data, alu_a, alu_b, alu_and, alu_add);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_sub_norsp%0d: rv=%0b, required 0", i, rsp_valid); end
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_tie: r0=%0b r1=%0b, required 1/0", req0_ready, req1_ready);
    end
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || alu_and !== 1'b0 || alu_add !== 1'b0) begin
        errors++;
        $display("FAIL drop_valid%0d: rv=%0b and=%0b add=%0b, required 0", i, rsp_valid, alu_and, alu_add);
      end
    end
  endtask

  task automatic test_random();
    bit pend = 1'b0, last = 1'b1, e0, e1, erv, exp_id = 1'b0;
    int age = 0, lat = 2;
    logic [W-1:0] exp_data = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
      req0_op = 2'($urandom); req0_a = 16'($urandom); req0_b = 16'($urandom);
      req1_op = 2'($urandom); req1_a = 16'($urandom); req1_b = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      e0 = 1'b0; e1 = 1'b0;
      if (!pend) begin
        if (req0_valid && req1_valid) begin
          if (last) e0 = 1'b1; else e1 = 1'b1;
        end else begin
          e0 = req0_valid; e1 = req1_valid;
        end
      end
      erv = pend && (age >= lat);
      checks++;
      if (req0_ready !== e0 || req1_ready !== e1) begin
        errors++;
        $display("FAIL rand_ready c%0d: r0=%0b r1=%0b, required %0b/%0b", cyc, req0_ready, req1_ready, e0, e1);
      end
      checks++;
      if (rsp_valid !== erv) begin
        errors++;
        $display("FAIL rand_rsp_valid c%0d: %0b, required %0b", cyc, rsp_valid, erv);
      end
      if (erv) begin
        checks++;
        if (rsp_data !== exp_data || rsp_id !== exp_id) begin
          errors++;
          $display("FAIL rand_rsp c%0d: data=%h id=%0b, required %h/%0b", cyc, rsp_data, rsp_id, exp_data, exp_id);
        end
      end
      if (e0 || e1) begin
        pend = 1'b1; age = 1; last = e1; exp_id = e1;
        if (e1) begin
          lat = (req1_op == 2'd2) ? 3 : 2;
          exp_data = ref_result(req1_op, req1_a, req1_b);
        end else begin
          lat = (req0_op == 2'd2) ? 3 : 2;
          exp_data = ref_result(req0_op, req0_a, req0_b);
        end
      end else if (pend) begin
        if (erv && rsp_ready) pend = 1'b0;
        else age++;
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_sub_wrap();
    test_fairness();
    test_pass();
    test_backpressure();
    test_reset_mid_sub();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
